// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: base opcode constants and hazard-controller state encoding.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic {
    HZ_RUN   = 1'b0,
    HZ_STALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/reg_use_decode.sv
// Source-register usage decode from the base opcode; shared with the forwarding unit.
module reg_use_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       uses_rs1,
  output logic       uses_rs2
);

  // JAL, LUI, AUIPC and unrecognised opcodes read no source registers
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
        uses_rs1 = 1'b1;
      end
      OPC_STORE, OPC_BRANCH, OPC_OP: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall and EX-redirect flush sequencing for the 5-stage pipeline front end.
// Optional HAZARD_PERF_EN adds saturating stall/flush event counters.
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_id_inst,
  input  logic        if_id_valid,
  input  logic        id_ex_memread,
  input  logic [4:0]  id_ex_rd,
  input  logic        ex_redirect,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        stall_active
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);

  localparam logic [CNT_W-1:0] STALL_RELOAD = CNT_W'(LOAD_STALL_CYCLES - 1);

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_active_q, stall_active_d;
  logic             uses_rs1, uses_rs2;
  logic             hz;
  logic             unused_inst_bits;

  assign unused_inst_bits = ^{if_id_inst[31:25], if_id_inst[14:7]};

  reg_use_decode u_reg_use_decode (
    .opcode   (if_id_inst[6:0]),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  assign hz = if_id_valid & id_ex_memread & (id_ex_rd != 5'd0) &
              ((uses_rs1 & (if_id_inst[19:15] == id_ex_rd)) |
               (uses_rs2 & (if_id_inst[24:20] == id_ex_rd)));

  // Next-state and output decode; redirect outranks any stall, reset forces a bubble
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    if (!rst_n) begin
      state_d      = HZ_RUN;
      cnt_d        = '0;
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b0;
    end else if (ex_redirect) begin
      state_d      = HZ_RUN;
      cnt_d        = '0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
    end else begin
      case (state_q)
        HZ_RUN: begin
          if (hz) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = HZ_STALL;
              cnt_d   = STALL_RELOAD;
            end else begin
              state_d = HZ_RUN;
              cnt_d   = '0;
            end
          end else begin
            state_d = HZ_RUN;
            cnt_d   = '0;
          end
        end
        // hz is not re-checked here: the bubble already cleared id_ex_memread
        HZ_STALL: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = HZ_RUN;
            cnt_d   = '0;
          end else begin
            state_d = HZ_STALL;
            cnt_d   = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = HZ_RUN;
          cnt_d   = '0;
        end
      endcase
    end
    stall_active_d = (state_d == HZ_STALL);
  end

  // State, counter and registered stall indicator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= HZ_RUN;
      cnt_q          <= '0;
      stall_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_active_q <= stall_active_d;
    end
  end

  assign stall_active = stall_active_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count_q, stall_count_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Saturating event counters
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (id_ex_bubble && !ex_redirect && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
    if (ex_redirect && (flush_count_q != 32'hFFFF_FFFF)) begin
      flush_count_d = flush_count_q + 32'd1;
    end else begin
      flush_count_d = flush_count_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with a single-cycle stall, one with a 3-cycle stall.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_id_inst;
  logic        if_id_valid;
  logic        id_ex_memread;
  logic [4:0]  id_ex_rd;
  logic        ex_redirect;

  logic pc_write1, if_id_write1, id_ex_bubble1, if_id_flush1, stall_active1;
  logic pc_write3, if_id_write3, id_ex_bubble3, if_id_flush3, stall_active3;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count1, flush_count1, stall_count3, flush_count3;
`endif

  int checks;
  int failures;

  // {pc_write, if_id_write, id_ex_bubble, if_id_flush, stall_active}
  localparam logic [4:0] RUN_O     = 5'b11000;
  localparam logic [4:0] HZ_O      = 5'b00100;
  localparam logic [4:0] STALL_O   = 5'b00101;
  localparam logic [4:0] FLUSH_O   = 5'b11110;
  localparam logic [4:0] FLUSH_S_O = 5'b11111;
  localparam logic [4:0] RST_O     = 5'b00100;

  logic [4:0] o1, o3;
  assign o1 = {pc_write1, if_id_write1, id_ex_bubble1, if_id_flush1, stall_active1};
  assign o3 = {pc_write3, if_id_write3, id_ex_bubble3, if_id_flush3, stall_active3};

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(3)) dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_id_inst    (if_id_inst),
    .if_id_valid   (if_id_valid),
    .id_ex_memread (id_ex_memread),
    .id_ex_rd      (id_ex_rd),
    .ex_redirect   (ex_redirect),
    .pc_write      (pc_write1),
    .if_id_write   (if_id_write1),
    .id_ex_bubble  (id_ex_bubble1),
    .if_id_flush   (if_id_flush1),
    .stall_active  (stall_active1)
`ifdef HAZARD_PERF_EN
    ,
    .stall_count   (stall_count1),
    .flush_count   (flush_count1)
`endif
  );

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(3)) dut3 (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_id_inst    (if_id_inst),
    .if_id_valid   (if_id_valid),
    .id_ex_memread (id_ex_memread),
    .id_ex_rd      (id_ex_rd),
    .ex_redirect   (ex_redirect),
    .pc_write      (pc_write3),
    .if_id_write   (if_id_write3),
    .id_ex_bubble  (id_ex_bubble3),
    .if_id_flush   (if_id_flush3),
    .stall_active  (stall_active3)
`ifdef HAZARD_PERF_EN
    ,
    .stall_count   (stall_count3),
    .flush_count   (flush_count3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    if_id_inst    = 32'h0000_0013;
    if_id_valid   = 1'b1;
    id_ex_memread = 1'b0;
    id_ex_rd      = 5'd0;
    ex_redirect   = 1'b0;

    #1;
    chk("reset_out_1", {27'd0, o1}, {27'd0, RST_O});
    chk("reset_out_3", {27'd0, o3}, {27'd0, RST_O});
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    chk("run_idle_1", {27'd0, o1}, {27'd0, RUN_O});
    chk("run_idle_3", {27'd0, o3}, {27'd0, RUN_O});

    // load-use on rs1: add x6,x5,x2 behind load to x5
    cyc();
    id_ex_memread = 1'b1;
    id_ex_rd      = 5'd5;
    if_id_inst    = 32'h0022_8333;
    #1;
    chk("rs1_hz_c1_1", {27'd0, o1}, {27'd0, HZ_O});
    chk("rs1_hz_c1_3", {27'd0, o3}, {27'd0, HZ_O});
    cyc();
    id_ex_memread = 1'b0;
    #1;
    chk("rs1_hz_c2_1", {27'd0, o1}, {27'd0, RUN_O});
    chk("rs1_hz_c2_3", {27'd0, o3}, {27'd0, STALL_O});
    cyc();
    chk("rs1_hz_c3_1", {27'd0, o1}, {27'd0, RUN_O});
    chk("rs1_hz_c3_3", {27'd0, o3}, {27'd0, STALL_O});
    cyc();
    chk("rs1_hz_c4_3", {27'd0, o3}, {27'd0, RUN_O});

    // false-match filters
    id_ex_memread = 1'b1;
    id_ex_rd      = 5'd5;
    if_id_inst    = 32'h0002_806F;
    #1;
    chk("jal_nohz_1", {27'd0, o1}, {27'd0, RUN_O});
    chk("jal_nohz_3", {27'd0, o3}, {27'd0, RUN_O});
    if_id_inst = 32'h0051_2303;
    #1;
    chk("lw_rs2field_nohz_1", {27'd0, o1}, {27'd0, RUN_O});
    id_ex_rd   = 5'd0;
    if_id_inst = 32'h0000_0333;
    #1;
    chk("rd0_nohz_1", {27'd0, o1}, {27'd0, RUN_O});
    chk("rd0_nohz_3", {27'd0, o3}, {27'd0, RUN_O});
    id_ex_rd    = 5'd5;
    if_id_inst  = 32'h0022_8333;
    if_id_valid = 1'b0;
    #1;
    chk("invalid_nohz_1", {27'd0, o1}, {27'd0, RUN_O});
    chk("invalid_nohz_3", {27'd0, o3}, {27'd0, RUN_O});
    cyc();
    chk("filters_nostall_3", {27'd0, o3}, {27'd0, RUN_O});

    // rs2 hazard (add x6,x2,x5), then redirect on the second stall cycle
    if_id_valid = 1'b1;
    if_id_inst  = 32'h0051_0333;
    #1;
    chk("rs2_hz_1", {27'd0, o1}, {27'd0, HZ_O});
    chk("rs2_hz_3", {27'd0, o3}, {27'd0, HZ_O});
    cyc();
    id_ex_memread = 1'b0;
    #1;
    chk("abort_stall1_3", {27'd0, o3}, {27'd0, STALL_O});
    cyc();
    ex_redirect = 1'b1;
    #1;
    chk("abort_redirect_3", {27'd0, o3}, {27'd0, FLUSH_S_O});
    chk("abort_redirect_1", {27'd0, o1}, {27'd0, FLUSH_O});
    cyc();
    ex_redirect = 1'b0;
    #1;
    chk("abort_after_3", {27'd0, o3}, {27'd0, RUN_O});

    // simultaneous hazard and redirect
    id_ex_memread = 1'b1;
    if_id_inst    = 32'h0022_8333;
    ex_redirect   = 1'b1;
    #1;
    chk("hz_redir_1", {27'd0, o1}, {27'd0, FLUSH_O});
    chk("hz_redir_3", {27'd0, o3}, {27'd0, FLUSH_O});
    cyc();
    ex_redirect   = 1'b0;
    id_ex_memread = 1'b0;
    #1;
    chk("hz_redir_after_3", {27'd0, o3}, {27'd0, RUN_O});

    // reset mid-stall
    id_ex_memread = 1'b1;
    #1;
    chk("rst_hz_3", {27'd0, o3}, {27'd0, HZ_O});
    cyc();
    id_ex_memread = 1'b0;
    #1;
    chk("rst_pre_stall_3", {27'd0, o3}, {27'd0, STALL_O});
    rst_n = 1'b0;
    #1;
    chk("rst_async_3", {27'd0, o3}, {27'd0, RST_O});
    rst_n = 1'b1;
    #1;
    chk("rst_release_3", {27'd0, o3}, {27'd0, RUN_O});
    cyc();
    chk("rst_release_c2_3", {27'd0, o3}, {27'd0, RUN_O});
`ifdef HAZARD_PERF_EN
    chk("perf_stall_cnt_3", stall_count3, 32'd0);
    chk("perf_flush_cnt_3", flush_count3, 32'd0);
    // one hazard cycle and one redirect cycle
    id_ex_memread = 1'b1;
    cyc();
    id_ex_memread = 1'b0;
    ex_redirect   = 1'b1;
    cyc();
    ex_redirect = 1'b0;
    #1;
    chk("perf_stall_cnt_1", stall_count1, 32'd1);
    chk("perf_flush_cnt_1", flush_count1, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
